duc_dds_sequencer: RTL

DUC_DDS_SEQUENCER -- requirements
Module: duc_dds_sequencer

---
 rtl/duc_dds_sequencer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/duc_dds_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : duc_dds_sequencer
// Brief    : Sequences a DDS (reset, pipeline prime, run) and streams its
//            sine/cosine samples downstream as counted or continuous bursts.
//            Optional phase-period marker: DUC_DDS_SEQ_PERIOD_MARK_EN.
// Revision : 1.0  initial release
// ============================================================================
module duc_dds_sequencer #(
    parameter int WIDTH        = 36,
    parameter int LUT_PERIOD   = 500,
    parameter int PRIME_CYCLES = 4
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic [15:0]      i_burst_len,
    output logic             o_dds_reset,
    output logic             o_dds_ready,
    input  logic [WIDTH-1:0] i_dds_cosine,
    input  logic [WIDTH-1:0] i_dds_sine,
    output logic [WIDTH-1:0] o_cosine_data,
    output logic [WIDTH-1:0] o_sine_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_period_start,
    output logic             o_busy,
    output logic             o_done
);

    localparam int PRIME_W = (PRIME_CYCLES > 1) ? $clog2(PRIME_CYCLES) : 1;
    localparam logic [PRIME_W-1:0] PRIME_LAST = PRIME_W'(PRIME_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        PRIME = 2'd2,
        RUN   = 2'd3
    } state_t;

    state_t               state;
    logic [15:0]          burst_len;
    logic [15:0]          xfer_count;
    logic [PRIME_W-1:0]   prime_count;
    logic                 valid_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 dds_reset_q;
    logic                 transfer;
    logic                 last_xfer;
    logic                 prime_exit;

    // valid_q is high exactly while in RUN, so a transfer implies RUN
    assign transfer   = valid_q & i_ready;
    assign last_xfer  = (burst_len != 16'd0) && (xfer_count == burst_len - 16'd1);
    assign prime_exit = (state == PRIME) && (prime_count == PRIME_LAST) && !i_stop;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state       <= IDLE;
            burst_len   <= 16'd0;
            xfer_count  <= 16'd0;
            prime_count <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dds_reset_q <= 1'b1;
        end else begin
            done_q      <= 1'b0;
            dds_reset_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start && !i_stop) begin
                        state       <= SYNC;
                        burst_len   <= i_burst_len;
                        xfer_count  <= 16'd0;
                        busy_q      <= 1'b1;
                        dds_reset_q <= 1'b1;
                    end
                end
                SYNC: begin
                    if (i_stop) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        state       <= PRIME;
                        prime_count <= '0;
                    end
                end
                PRIME: begin
                    if (i_stop) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else if (prime_count == PRIME_LAST) begin
                        state   <= RUN;
                        valid_q <= 1'b1;
                    end else begin
                        prime_count <= prime_count + PRIME_W'(1);
                    end
                end
                RUN: begin
                    // in continuous mode the counter simply wraps; it never ends the run
                    if (transfer) begin
                        xfer_count <= xfer_count + 16'd1;
                    end
                    if (i_stop || (transfer && last_xfer)) begin
                        state   <= IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // DDS advances throughout PRIME and only on accepted samples in RUN
    assign o_dds_ready   = (state == PRIME) | transfer;
    assign o_dds_reset   = dds_reset_q;
    assign o_valid       = valid_q;
    assign o_busy        = busy_q;
    assign o_done        = done_q;
    assign o_cosine_data = i_dds_cosine;
    assign o_sine_data   = i_dds_sine;

`ifdef DUC_DDS_SEQ_PERIOD_MARK_EN
    localparam int PHASE_W = (LUT_PERIOD > 1) ? $clog2(LUT_PERIOD) : 1;
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(LUT_PERIOD - 1);

    logic [PHASE_W-1:0] phase;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            phase <= '0;
        end else if (prime_exit) begin
            phase <= '0;
        end else if (transfer) begin
            phase <= (phase == PHASE_LAST) ? '0 : phase + PHASE_W'(1);
        end
    end

    assign o_period_start = valid_q & (phase == '0);
`else
    assign o_period_start = 1'b0;
`endif

endmodule
`default_nettype wire
